// File: rtl/led_pkg.sv
// Shared arbiter state encoding and LED geometry.
package led_pkg;

    localparam int LED_W = 24;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first set bit of req_i at or after start_i, wrapping modulo N.
module rr_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0] req_i,
    input  logic [1:0]   start_i,
    output logic         found_o,
    output logic [1:0]   idx_o
);

    // Scan from the farthest candidate back to start_i so the nearest one wins.
    always_comb begin
        int p;
        p       = 0;
        found_o = 1'b0;
        idx_o   = 2'd0;
        for (int k = N - 1; k >= 0; k--) begin
            p = (int'(start_i) + k) % N;
            if (req_i[p]) begin
                found_o = 1'b1;
                idx_o   = 2'(p);
            end else begin
                found_o = found_o;
            end
        end
    end

endmodule

// File: rtl/led_array_arbiter.sv
// Time-sliced round-robin arbiter handing a 24-bit LED board to one of N_REQ requesters.
module led_array_arbiter
    import led_pkg::*;
#(
    parameter int               N_REQ        = 3,
    parameter int               SLICE_CYCLES = 12_000_000,
    parameter logic [LED_W-1:0] IDLE_PATTERN = 24'h000001
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [LED_W*N_REQ-1:0] pattern,
    output logic [N_REQ-1:0]       gnt,
    output logic [1:0]             owner_id,
    output logic                   busy,
    output logic [LED_W-1:0]       ioboard_leds
);

    localparam int            CW      = $clog2(SLICE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(SLICE_CYCLES - 1);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q;
    logic [LED_W-1:0] leds_q, leds_d;

    logic [N_REQ-1:0] pick_vec_s;
    logic [N_REQ-1:0] pick_onehot_s;
    logic [1:0]       pick_start_s;
    logic [1:0]       pick_idx_s;
    logic             pick_found_s;
    logic             owner_req_s;

    // While granted, the owner's bit is masked so the search only sees other requesters;
    // the search starts one past the previous owner in every state.
    always_comb begin
        pick_start_s = last_q + 2'd1;
        if (state_q == ST_GRANT) begin
            pick_vec_s = req & ~gnt_q;
        end else begin
            pick_vec_s = req;
        end
        owner_req_s = |(req & gnt_q);
    end

    rr_pick #(
        .N(N_REQ)
    ) u_rr_pick (
        .req_i  (pick_vec_s),
        .start_i(pick_start_s),
        .found_o(pick_found_s),
        .idx_o  (pick_idx_s)
    );

    // Decode the picked index into the one-hot grant it would produce.
    always_comb begin
        pick_onehot_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pick_onehot_s[i] = (pick_idx_s == 2'(i));
        end
    end

    // Next-state, grant and slice-counter logic.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_d = ST_GRANT;
                    gnt_d   = pick_onehot_s;
                    owner_d = pick_idx_s;
                    last_d  = pick_idx_s;
                    cnt_d   = '0;
                end else begin
                    gnt_d   = '0;
                    owner_d = 2'd0;
                end
            end
            ST_GRANT: begin
                if (!owner_req_s || (cnt_q == CNT_MAX)) begin
                    if (pick_found_s) begin
                        gnt_d   = pick_onehot_s;
                        owner_d = pick_idx_s;
                        last_d  = pick_idx_s;
                        cnt_d   = '0;
                    end else if (!owner_req_s) begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        owner_d = 2'd0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = CNT_MAX;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                owner_d = 2'd0;
                cnt_d   = '0;
            end
        endcase
    end

    // LED drive follows the currently registered owner, one cycle behind the grant.
    always_comb begin
        if (state_q == ST_GRANT) begin
            leds_d = pattern[int'(owner_q)*LED_W +: LED_W];
        end else begin
            leds_d = IDLE_PATTERN;
        end
    end

    // State and output registers; reset seeds last_q so requester 0 is favoured first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            owner_q <= 2'd0;
            last_q  <= 2'(N_REQ - 1);
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            leds_q  <= IDLE_PATTERN;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            busy_q  <= |gnt_d;
            leds_q  <= leds_d;
        end
    end

    assign gnt          = gnt_q;
    assign owner_id     = owner_q;
    assign busy         = busy_q;
    assign ioboard_leds = leds_q;

endmodule

// File: tb/tb_led_array_arbiter.sv
// Self-checking bench for led_array_arbiter: directed table, corner sequences, random vs model.
module tb_led_array_arbiter;

    localparam int          N     = 3;
    localparam int          SLICE = 8;
    localparam logic [23:0] IDLEP = 24'h000001;

    logic          clk;
    logic          reset;
    logic [N-1:0]  req;
    logic [71:0]   pattern;
    logic [N-1:0]  gnt;
    logic [1:0]    owner_id;
    logic          busy;
    logic [23:0]   ioboard_leds;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // reference model: owner -1 means nobody holds the board
    int          m_owner;
    int          m_last;
    int          m_elapsed;
    logic [23:0] m_leds;

    led_array_arbiter #(
        .N_REQ(N),
        .SLICE_CYCLES(SLICE),
        .IDLE_PATTERN(IDLEP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .pattern(pattern),
        .gnt(gnt),
        .owner_id(owner_id),
        .busy(busy),
        .ioboard_leds(ioboard_leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic int rr_find(input logic [2:0] r, input int from, input int excl);
        for (int k = 0; k < N; k++) begin
            int p;
            p = (from + k) % N;
            if (p != excl && r[p]) return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_last    = N - 1;
        m_elapsed = 0;
        m_leds    = IDLEP;
    endtask

    task automatic model_step();
        logic [23:0] nl;
        int n;
        nl = (m_owner >= 0) ? pattern[24*m_owner +: 24] : IDLEP;
        if (m_owner < 0) begin
            n = rr_find(req, m_last + 1, -1);
            if (n >= 0) begin m_owner = n; m_last = n; m_elapsed = 0; end
        end else if (!req[m_owner]) begin
            n = rr_find(req, m_owner + 1, m_owner);
            if (n >= 0) begin m_owner = n; m_last = n; end
            else m_owner = -1;
            m_elapsed = 0;
        end else if (m_elapsed == SLICE - 1) begin
            n = rr_find(req, m_owner + 1, m_owner);
            if (n >= 0) begin m_owner = n; m_last = n; m_elapsed = 0; end
        end else begin
            m_elapsed++;
        end
        m_leds = nl;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_model(input string tag);
        logic [2:0] eg;
        eg = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
        check({tag, "_gnt"},   32'(gnt),          32'(eg));
        check({tag, "_owner"}, 32'(owner_id),     (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check({tag, "_busy"},  32'(busy),         (m_owner >= 0) ? 32'd1 : 32'd0);
        check({tag, "_leds"},  32'(ioboard_leds), 32'(m_leds));
    endtask

    typedef struct {
        logic [2:0]  req;
        int          n;
        logic [2:0]  gnt;
        logic [1:0]  own;
        logic        busy;
        logic [23:0] leds;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int illegal, changes, glitch, hold;
        logic [2:0] prev;

        tbl[0]  = '{3'b000, 1, 3'b000, 2'd0, 1'b0, 24'h000001};
        tbl[1]  = '{3'b111, 1, 3'b001, 2'd0, 1'b1, 24'h000001};
        tbl[2]  = '{3'b111, 1, 3'b001, 2'd0, 1'b1, 24'h111111};
        tbl[3]  = '{3'b111, 6, 3'b001, 2'd0, 1'b1, 24'h111111};
        tbl[4]  = '{3'b111, 1, 3'b010, 2'd1, 1'b1, 24'h111111};
        tbl[5]  = '{3'b111, 1, 3'b010, 2'd1, 1'b1, 24'h222222};
        tbl[6]  = '{3'b101, 1, 3'b100, 2'd2, 1'b1, 24'h222222};
        tbl[7]  = '{3'b101, 1, 3'b100, 2'd2, 1'b1, 24'h333333};
        tbl[8]  = '{3'b000, 1, 3'b000, 2'd0, 1'b0, 24'h333333};
        tbl[9]  = '{3'b000, 1, 3'b000, 2'd0, 1'b0, 24'h000001};
        tbl[10] = '{3'b011, 1, 3'b001, 2'd0, 1'b1, 24'h000001};

        reset   = 1'b1;
        req     = '0;
        pattern = {24'h333333, 24'h222222, 24'h111111};
        model_reset();
        @(posedge clk);
        #1;
        check("rst_gnt",  32'(gnt),          32'd0);
        check("rst_busy", 32'(busy),         32'd0);
        check("rst_own",  32'(owner_id),     32'd0);
        check("rst_leds", 32'(ioboard_leds), 32'(IDLEP));

        // directed table
        do_reset();
        for (int i = 0; i < 11; i++) begin
            req = tbl[i].req;
            for (int c = 0; c < tbl[i].n; c++) tick();
            check($sformatf("tbl%0d_gnt", i),  32'(gnt),          32'(tbl[i].gnt));
            check($sformatf("tbl%0d_own", i),  32'(owner_id),     32'(tbl[i].own));
            check($sformatf("tbl%0d_busy", i), 32'(busy),         32'(tbl[i].busy));
            check($sformatf("tbl%0d_leds", i), 32'(ioboard_leds), 32'(tbl[i].leds));
        end

        // two requesters alternate every SLICE cycles with clean handovers
        do_reset();
        req = 3'b011;
        illegal = 0;
        changes = 0;
        prev = 3'b000;
        for (int c = 1; c <= 32; c++) begin
            tick();
            if (gnt != 3'b001 && gnt != 3'b010) illegal++;
            if (c > 1 && gnt != prev) changes++;
            prev = gnt;
        end
        check("alt_illegal", 32'(illegal), 32'd0);
        check("alt_changes", 32'(changes), 32'd3);

        // lone requester keeps the board past expiry, then yields at once
        do_reset();
        req = 3'b001;
        glitch = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (gnt != 3'b001) glitch++;
        end
        check("sat_glitch", 32'(glitch), 32'd0);
        check("sat_busy",   32'(busy),   32'd1);
        req = 3'b011;
        tick();
        check("sat_rotate", 32'(gnt), 32'b010);

        // owner drops early; new owner gets a full fresh slice
        do_reset();
        req = 3'b101;
        repeat (3) tick();
        check("drop_pre", 32'(gnt), 32'b001);
        req = 3'b100;
        tick();
        check("drop_gnt", 32'(gnt), 32'b100);
        req = 3'b111;
        hold = 1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (gnt == 3'b100) hold++;
            else break;
        end
        check("drop_slice", 32'(hold), 32'd8);
        check("drop_next",  32'(gnt),  32'b001);

        // asynchronous reset in the middle of requester 2's slice
        do_reset();
        req = 3'b111;
        repeat (17) tick();
        check("ar_owner2", 32'(gnt), 32'b100);
        repeat (2) tick();
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check("ar_gnt",  32'(gnt),          32'd0);
        check("ar_busy", 32'(busy),         32'd0);
        check("ar_own",  32'(owner_id),     32'd0);
        check("ar_leds", 32'(ioboard_leds), 32'(IDLEP));
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        check("ar_first", 32'(gnt), 32'b001);

        // random traffic against the reference model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < N; j++) pattern[24*j +: 24] = 24'($urandom());
            end
            tick();
            check_model($sformatf("rnd%0d", c));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/led_array_arbiter.md
LED_ARRAY_ARBITER -- requirements
Module: led_array_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of requesters (2..4).
REQ-002 SHALL have parameter SLICE_CYCLES, default 12_000_000, minimum grant time-slice in clk cycles (>=2).
REQ-003 SHALL have parameter IDLE_PATTERN, default 24'h000001, LED value driven when no requester is granted.
REQ-004 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req, input, N_REQ, per-requester request level.
REQ-007 SHALL have port pattern, input, 24*N_REQ, flattened LED patterns; requester i owns bits [24*i+23:24*i].
REQ-008 SHALL have port gnt, output, N_REQ, one-hot grant, all zero when idle.
REQ-009 SHALL have port owner_id, output, 2, index of current owner, 0 when idle.
REQ-010 SHALL have port busy, output, 1, high while any grant is active.
REQ-011 SHALL have port ioboard_leds, output, 24, registered LED drive.

Function
REQ-012 SHALL implement FSM with states IDLE and GRANT.
REQ-013 In IDLE, when any req bit is high, SHALL enter GRANT next cycle, granting the first requesting index found round-robin starting at last_owner+1 (mod N_REQ).
REQ-014 In GRANT, slice counter SHALL increment each cycle from 0 and saturate at SLICE_CYCLES-1 (slice expired).
REQ-015 In GRANT, if owner's req drops, SHALL release next cycle: grant next requester round-robin after owner if any req is high (counter reset to 0), else return to IDLE.
REQ-016 In GRANT, at slice expiry with owner's req still high, SHALL rotate to the next other requester round-robin if any other req is high, counter reset to 0; otherwise SHALL keep owner and hold counter saturated.
REQ-017 Before slice expiry, other requests SHALL NOT preempt the owner.
REQ-018 Handover SHALL take exactly one cycle: gnt changes directly from old one-hot to new one-hot, never two bits high.
REQ-019 last_owner SHALL update to the new owner index on every grant.
REQ-020 ioboard_leds SHALL equal pattern slice of the owner, sampled each cycle (1-cycle latency from pattern change), and IDLE_PATTERN when idle.
REQ-021 gnt, owner_id, busy and ioboard_leds SHALL all be registered; busy = |gnt.
REQ-022 req bits for indices >= N_REQ do not exist; owner_id SHALL be zero-extended to 2 bits.
REQ-023 Slice counter width SHALL be $clog2(SLICE_CYCLES); no overflow wrap permitted.

Reset
REQ-024 On reset assertion, SHALL immediately (asynchronously) force: state IDLE, gnt 0, owner_id 0, busy 0, ioboard_leds IDLE_PATTERN, counter 0, last_owner N_REQ-1.
REQ-025 Reset asserted mid-grant SHALL drop grant without waiting for slice; first grant after release SHALL favour requester 0.
REQ-026 Release of reset SHALL take effect on the first rising clk edge after deassertion; no grant issued in that same cycle's prior state.

Structure
REQ-027 SHALL place state encoding (IDLE, GRANT) and LED width constant (24) in shared package led_pkg.
REQ-028 SHALL use one sub-module rr_pick (combinational: req vector, start index -> found flag, index) reused for IDLE grant, release and rotation.
REQ-029 SHALL contain no other sub-modules and no clock gating.

Verification (N_REQ=3, SLICE_CYCLES=8, IDLE_PATTERN=24'h000001)
REQ-030 Reset then req=3'b111 -> gnt=3'b001 one cycle later, ioboard_leds=pattern[23:0] a further cycle later, busy=1.
REQ-031 req=3'b011 held -> gnt toggles 001 -> 010 -> 001 every 8 cycles, never 3'b011 or 0 between.
REQ-032 req=3'b001 held alone 30 cycles -> gnt stays 001, counter saturates at 7, no glitch; then req1 raised -> gnt=010 next cycle.
REQ-033 Owner 0 drops req at cycle 3 of slice with req=3'b100 -> gnt=100 next cycle, counter restarts at 0.
REQ-034 All req dropped -> gnt=000, busy=0, owner_id=0, ioboard_leds=24'h000001 within 2 cycles.
REQ-035 reset pulsed mid-grant of requester 2 with req=3'b111 -> outputs zeroed/IDLE_PATTERN asynchronously; after release gnt=001 first.
